// File: rtl/mvm_noc_top.sv
// Single MVM tile on a NoC AXI-Stream endpoint: weight rows are written into 64 per-lane
// register files, and an input vector triggers a 64-lane int8 dot product that is streamed back.
module mvm_noc_top #(
    parameter int DATAW       = 512,
    parameter int IDW         = 8,
    parameter int DESTW       = 12,
    parameter int USERW       = 75,
    parameter int NUM_LANES   = 64,
    parameter int RF_DEPTH    = 512,
    parameter int TILE_ID     = 1,
    parameter int RESULT_DEST = 0,
    parameter int SHIFT       = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             AXIS_S_TVALID,
    output logic             AXIS_S_TREADY,
    input  logic [DATAW-1:0] AXIS_S_TDATA,
    input  logic             AXIS_S_TLAST,
    input  logic [IDW-1:0]   AXIS_S_TID,
    input  logic [USERW-1:0] AXIS_S_TUSER,
    input  logic [DESTW-1:0] AXIS_S_TDEST,
    output logic             AXIS_M_TVALID,
    input  logic             AXIS_M_TREADY,
    output logic [DATAW-1:0] AXIS_M_TDATA,
    output logic             AXIS_M_TLAST,
    output logic [IDW-1:0]   AXIS_M_TID,
    output logic [USERW-1:0] AXIS_M_TUSER,
    output logic [DESTW-1:0] AXIS_M_TDEST
);
    localparam int AW    = $clog2(RF_DEPTH);
    localparam int ELEMS = DATAW / 8;

    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, MAC = 2'd2, OUT = 2'd3} state_t;

    state_t                   state_r, state_nxt_s;
    logic                     ready_r, valid_r;
    logic [DATAW-1:0]         data_r, x_r, res_s;
    logic [IDW-1:0]           tid_r, tid_lat_r;
    logic [DESTW-1:0]         dest_r;
    logic [AW-1:0]            addr_r, addr_s;
    logic [1:0]               op_s;
    logic                     hit_s, wr_s, vec_s;
    logic [DATAW-1:0]         rf_r  [NUM_LANES][RF_DEPTH];
    logic [DATAW-1:0]         row_r [NUM_LANES];
    logic signed [21:0]       sum_s [NUM_LANES];
    logic signed [21:0]       sum_r [NUM_LANES];
    logic                     unused_tlast_s;

    // Full-precision signed int8 dot product; each product fits 16 bits, the sum fits 22.
    function automatic logic signed [21:0] dot8(input logic [DATAW-1:0] w, input logic [DATAW-1:0] x);
        logic signed [21:0] acc;
        logic signed [15:0] a, b, p;
        acc = 22'sd0;
        for (int i = 0; i < ELEMS; i++) begin
            a   = {{8{w[8*i+7]}}, w[8*i +: 8]};
            b   = {{8{x[8*i+7]}}, x[8*i +: 8]};
            p   = a * b;
            acc = acc + {{6{p[15]}}, p};
        end
        return acc;
    endfunction

    function automatic logic [7:0] sat8(input logic signed [21:0] s);
        logic signed [21:0] sh;
        sh = s >>> SHIFT;
        if (sh > 22'sd127) begin
            return 8'h7F;
        end else if (sh < -22'sd128) begin
            return 8'h80;
        end else begin
            return sh[7:0];
        end
    endfunction

    assign unused_tlast_s = AXIS_S_TLAST;
    assign addr_s = AXIS_S_TUSER[AW-1:0];
    assign op_s   = AXIS_S_TUSER[10:9];
    assign hit_s  = AXIS_S_TVALID && ready_r && (AXIS_S_TDEST == DESTW'(TILE_ID));
    assign wr_s   = hit_s && (op_s == 2'b11);
    assign vec_s  = hit_s && (op_s == 2'b10);

    assign AXIS_S_TREADY = ready_r;
    assign AXIS_M_TVALID = valid_r;
    assign AXIS_M_TDATA  = data_r;
    assign AXIS_M_TLAST  = valid_r;
    assign AXIS_M_TID    = tid_r;
    assign AXIS_M_TUSER  = {USERW{1'b0}};
    assign AXIS_M_TDEST  = dest_r;

    // Masked weight-row writes; RF contents deliberately have no reset.
    always_ff @(posedge CLK) begin
        for (int k = 0; k < NUM_LANES; k++) begin
            if (wr_s && AXIS_S_TUSER[11+k]) begin
                rf_r[k][addr_s] <= AXIS_S_TDATA;
            end
        end
    end

    // All lanes read the latched row address in READ.
    always_ff @(posedge CLK) begin
        if (state_r == READ) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                row_r[k] <= rf_r[k][addr_r];
            end
        end
    end

    // Per-lane dot products and packed saturated result.
    always_comb begin
        res_s = {DATAW{1'b0}};
        for (int k = 0; k < NUM_LANES; k++) begin
            sum_s[k]          = dot8(row_r[k], x_r);
            res_s[8*k +: 8]   = sat8(sum_r[k]);
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    if (vec_s) state_nxt_s = READ; else state_nxt_s = IDLE;
            READ:    state_nxt_s = MAC;
            MAC:     state_nxt_s = OUT;
            OUT:     if (valid_r && AXIS_M_TREADY) state_nxt_s = IDLE; else state_nxt_s = OUT;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, latched vector context, sums and registered stream outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= IDLE;
            ready_r   <= 1'b0;
            valid_r   <= 1'b0;
            data_r    <= {DATAW{1'b0}};
            tid_r     <= {IDW{1'b0}};
            dest_r    <= {DESTW{1'b0}};
            x_r       <= {DATAW{1'b0}};
            tid_lat_r <= {IDW{1'b0}};
            addr_r    <= {AW{1'b0}};
            for (int k = 0; k < NUM_LANES; k++) sum_r[k] <= 22'sd0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == IDLE);
            if (vec_s) begin
                x_r       <= AXIS_S_TDATA;
                tid_lat_r <= AXIS_S_TID;
                addr_r    <= addr_s;
            end
            if (state_r == MAC) begin
                for (int k = 0; k < NUM_LANES; k++) sum_r[k] <= sum_s[k];
            end
            // First OUT cycle loads the result; it then holds until the handshake.
            if (state_r == OUT && !valid_r) begin
                valid_r <= 1'b1;
                data_r  <= res_s;
                tid_r   <= tid_lat_r;
                dest_r  <= DESTW'(RESULT_DEST);
            end else if (state_r == OUT && AXIS_M_TREADY) begin
                valid_r <= 1'b0;
                data_r  <= {DATAW{1'b0}};
                tid_r   <= {IDW{1'b0}};
                dest_r  <= {DESTW{1'b0}};
            end
        end
    end
endmodule

// File: tb/tb_mvm_noc_top.sv
// Directed bench for mvm_noc_top: a SHIFT=0 tile and a SHIFT=14 tile share one input stream.
module tb_mvm_noc_top;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_valid = 1'b0;
    logic [511:0] s_data = '0;
    logic         s_last = 1'b0;
    logic [7:0]   s_id = '0;
    logic [74:0]  s_user = '0;
    logic [11:0]  s_dest = '0;
    logic         m_ready = 1'b1;
    logic         s_ready, m_valid, m_last, s_ready14, m_valid14, m_last14;
    logic [511:0] m_data, m_data14;
    logic [7:0]   m_id, m_id14;
    logic [74:0]  m_user, m_user14;
    logic [11:0]  m_dest, m_dest14;
    int           total = 0;
    int           bad = 0;
    logic [511:0] exp_v;

    always #5 clk = ~clk;

    mvm_noc_top #(.SHIFT(0)) dut (
        .CLK(clk), .RST(rst),
        .AXIS_S_TVALID(s_valid), .AXIS_S_TREADY(s_ready), .AXIS_S_TDATA(s_data),
        .AXIS_S_TLAST(s_last), .AXIS_S_TID(s_id), .AXIS_S_TUSER(s_user), .AXIS_S_TDEST(s_dest),
        .AXIS_M_TVALID(m_valid), .AXIS_M_TREADY(m_ready), .AXIS_M_TDATA(m_data),
        .AXIS_M_TLAST(m_last), .AXIS_M_TID(m_id), .AXIS_M_TUSER(m_user), .AXIS_M_TDEST(m_dest)
    );

    mvm_noc_top #(.SHIFT(14)) dut14 (
        .CLK(clk), .RST(rst),
        .AXIS_S_TVALID(s_valid), .AXIS_S_TREADY(s_ready14), .AXIS_S_TDATA(s_data),
        .AXIS_S_TLAST(s_last), .AXIS_S_TID(s_id), .AXIS_S_TUSER(s_user), .AXIS_S_TDEST(s_dest),
        .AXIS_M_TVALID(m_valid14), .AXIS_M_TREADY(m_ready), .AXIS_M_TDATA(m_data14),
        .AXIS_M_TLAST(m_last14), .AXIS_M_TID(m_id14), .AXIS_M_TUSER(m_user14), .AXIS_M_TDEST(m_dest14)
    );

    function automatic logic [511:0] rep(input logic [7:0] b);
        return {64{b}};
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and return #1 after the edge that accepted it.
    task automatic send(input logic [11:0] dest, input logic [1:0] op, input logic [8:0] addr,
                        input logic [63:0] mask, input logic [511:0] data, input logic [7:0] tid);
        int n;
        s_valid = 1'b1; s_dest = dest; s_user = {mask, op, addr}; s_data = data;
        s_id = tid; s_last = 1'b1;
        n = 0;
        while (!s_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("send_timeout", 512'(s_ready), 512'(1'b1));
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!m_valid && n < 12) begin
            tick();
            n++;
        end
        if (n >= 12) check(tag, 512'(m_valid), 512'(1'b1));
    endtask

    initial begin
        // Reset behaviour
        rst = 1'b1;
        repeat (3) tick();
        check("rst_s_ready", 512'(s_ready), 512'(1'b0));
        check("rst_m_valid", 512'(m_valid), 512'(1'b0));
        check("rst_m_data", m_data, 512'(0));
        rst = 1'b0;
        tick();
        check("idle_s_ready", 512'(s_ready), 512'(1'b1));
        check("idle_m_valid", 512'(m_valid), 512'(1'b0));

        // Broadcast all-ones weights, then all-ones vector: each lane is 64
        send(12'd1, 2'b11, 9'd1, {64{1'b1}}, rep(8'h01), 8'd0);
        send(12'd1, 2'b10, 9'd1, 64'd0, rep(8'h01), 8'd5);
        check("lat_t1_valid", 512'(m_valid), 512'(1'b0));
        tick();
        check("lat_t2_valid", 512'(m_valid), 512'(1'b0));
        tick();
        check("lat_t3_valid", 512'(m_valid), 512'(1'b0));
        tick();
        check("bcast_valid", 512'(m_valid), 512'(1'b1));
        check("bcast_data", m_data, rep(8'h40));
        check("bcast_last", 512'(m_last), 512'(1'b1));
        check("bcast_tid", 512'(m_id), 512'(8'd5));
        check("bcast_dest", 512'(m_dest), 512'(12'd0));
        check("bcast_user", 512'(m_user), 512'(0));
        tick();
        check("bcast_done_valid", 512'(m_valid), 512'(1'b0));
        check("bcast_done_ready", 512'(s_ready), 512'(1'b1));

        // One-hot lane writes: lane k weights all k; vector of 2s gives 128k, saturated
        for (int k = 0; k < 64; k++) begin
            send(12'd1, 2'b11, 9'd1, 64'd1 << k, rep(8'(k)), 8'd0);
        end
        send(12'd1, 2'b10, 9'd1, 64'd0, rep(8'h02), 8'd7);
        wait_valid("onehot_timeout");
        exp_v = rep(8'h7F);
        exp_v[7:0] = 8'h00;
        check("onehot_data", m_data, exp_v);
        check("onehot_tid", 512'(m_id), 512'(8'd7));
        tick();

        // Signed saturation and shift, at the top address
        send(12'd1, 2'b11, 9'd511, {64{1'b1}}, rep(8'h80), 8'd0);
        send(12'd1, 2'b10, 9'd511, 64'd0, rep(8'h7F), 8'd3);
        wait_valid("sat_timeout");
        check("sat_shift0", m_data, rep(8'h80));
        check("sat_valid14", 512'(m_valid14), 512'(1'b1));
        check("sat_shift14", m_data14, rep(8'hC0));
        tick();

        // Reserved op is consumed without effect
        send(12'd1, 2'b00, 9'd1, {64{1'b1}}, rep(8'h09), 8'd0);
        check("rsvd_ready", 512'(s_ready), 512'(1'b1));
        check("rsvd_valid", 512'(m_valid), 512'(1'b0));

        // Foreign-dest write is dropped; result held under backpressure
        send(12'd2, 2'b11, 9'd1, {64{1'b1}}, rep(8'h05), 8'd0);
        m_ready = 1'b0;
        send(12'd1, 2'b10, 9'd1, 64'd0, rep(8'h01), 8'd9);
        wait_valid("bp_timeout");
        exp_v = rep(8'h7F);
        exp_v[7:0]  = 8'h00;
        exp_v[15:8] = 8'h40;
        for (int c = 0; c < 10; c++) begin
            check("bp_data", m_data, exp_v);
            check("bp_valid", 512'(m_valid), 512'(1'b1));
            check("bp_tid", 512'(m_id), 512'(8'd9));
            check("bp_s_ready", 512'(s_ready), 512'(1'b0));
            tick();
        end
        m_ready = 1'b1;
        tick();
        check("bp_release_valid", 512'(m_valid), 512'(1'b0));
        check("bp_release_ready", 512'(s_ready), 512'(1'b1));

        // Reset during READ aborts the computation
        send(12'd1, 2'b10, 9'd511, 64'd0, rep(8'h7F), 8'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            check("abort_no_valid", 512'(m_valid), 512'(1'b0));
            tick();
        end
        send(12'd1, 2'b10, 9'd1, 64'd0, rep(8'h01), 8'd6);
        wait_valid("post_rst_timeout");
        check("post_rst_data", m_data, exp_v);
        check("post_rst_tid", 512'(m_id), 512'(8'd6));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
